// File: rtl/bootrom16_arb.sv
// Round-robin two-master Wishbone front end for the 16-bit boot ROM: each read is a single-cycle ROM strobe, ack two cycles after the request.
// Writes and ROM timeouts are answered with a one-cycle error; a master dropping cyc aborts its transfer silently.
module bootrom16_arb #(
  parameter int TIMEOUT = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // master 0: instruction fetch
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [1:0]  m0_sel_i,
  input  logic        m0_tga_i,
  output logic [15:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  // master 1: data port
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [1:0]  m1_sel_i,
  input  logic        m1_tga_i,
  output logic [15:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  // ROM side
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [1:0]  s_sel_o,
  output logic        s_tga_o,
  input  logic [15:0] s_dat_i,
  input  logic        s_ack_i
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          s_cyc_q, s_cyc_d;
  logic          s_stb_q, s_stb_d;
  logic [31:0]   s_adr_q, s_adr_d;
  logic [1:0]    s_sel_q, s_sel_d;
  logic          s_tga_q, s_tga_d;
  logic          m0_err_q, m0_err_d;
  logic          m1_err_q, m1_err_d;

  logic req0, req1, win, win_we, gnt_cyc;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  // On a tie the master that was not served last wins; otherwise the sole requester.
  always_comb begin
    win = 1'b0;
    if (req0 && req1) begin
      win = ~last_q;
    end else if (req1) begin
      win = 1'b1;
    end
  end

  assign win_we  = win ? m1_we_i : m0_we_i;
  assign gnt_cyc = grant_q ? m1_cyc_i : m0_cyc_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      tcnt_q   <= '0;
      s_cyc_q  <= 1'b0;
      s_stb_q  <= 1'b0;
      s_adr_q  <= '0;
      s_sel_q  <= '0;
      s_tga_q  <= 1'b0;
      m0_err_q <= 1'b0;
      m1_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      tcnt_q   <= tcnt_d;
      s_cyc_q  <= s_cyc_d;
      s_stb_q  <= s_stb_d;
      s_adr_q  <= s_adr_d;
      s_sel_q  <= s_sel_d;
      s_tga_q  <= s_tga_d;
      m0_err_q <= m0_err_d;
      m1_err_q <= m1_err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    tcnt_d   = tcnt_q;
    s_cyc_d  = s_cyc_q;
    s_stb_d  = s_stb_q;
    s_adr_d  = s_adr_q;
    s_sel_d  = s_sel_q;
    s_tga_d  = s_tga_q;
    m0_err_d = 1'b0;
    m1_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_d = win;
          last_d  = win;
          s_adr_d = win ? m1_adr_i : m0_adr_i;
          s_sel_d = win ? m1_sel_i : m0_sel_i;
          s_tga_d = win ? m1_tga_i : m0_tga_i;
          if (win_we) begin
            // Writes never touch the ROM.
            state_d  = ERR;
            s_cyc_d  = 1'b0;
            s_stb_d  = 1'b0;
            m0_err_d = ~win;
            m1_err_d = win;
          end else begin
            state_d = REQ;
            s_cyc_d = 1'b1;
            s_stb_d = 1'b1;
          end
        end
      end

      REQ: begin
        s_stb_d = 1'b0;
        if (!gnt_cyc) begin
          state_d = IDLE;
          s_cyc_d = 1'b0;
        end else begin
          state_d = WAIT;
          tcnt_d  = '0;
        end
      end

      WAIT: begin
        if (!gnt_cyc || s_ack_i) begin
          state_d = IDLE;
          s_cyc_d = 1'b0;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_d  = ERR;
          s_cyc_d  = 1'b0;
          m0_err_d = ~grant_q;
          m1_err_d = grant_q;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end

      ERR: begin
        state_d = IDLE;
        s_cyc_d = 1'b0;
        s_stb_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Ack is only forwarded while a transfer is outstanding and its owner is still on the bus.
  assign m0_ack_o = s_ack_i & (state_q == WAIT) & ~grant_q & m0_cyc_i;
  assign m1_ack_o = s_ack_i & (state_q == WAIT) &  grant_q & m1_cyc_i;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_err_o = m0_err_q;
  assign m1_err_o = m1_err_q;

  assign s_cyc_o = s_cyc_q;
  assign s_stb_o = s_stb_q;
  assign s_we_o  = 1'b0;
  assign s_adr_o = s_adr_q;
  assign s_sel_o = s_sel_q;
  assign s_tga_o = s_tga_q;

endmodule

// File: tb/tb_bootrom16_arb.sv
// Directed bench for bootrom16_arb with a registered little-endian ROM model on the slave side.
module tb_bootrom16_arb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_cyc_i, m0_stb_i, m0_we_i, m0_tga_i;
  logic [31:0] m0_adr_i;
  logic [1:0]  m0_sel_i;
  logic [15:0] m0_dat_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i, m1_tga_i;
  logic [31:0] m1_adr_i;
  logic [1:0]  m1_sel_i;
  logic [15:0] m1_dat_o;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o, s_tga_o;
  logic [31:0] s_adr_o;
  logic [1:0]  s_sel_o;
  logic [15:0] s_dat_i;
  logic        s_ack_i;

  logic        rom_en;
  logic        stray_ack;
  logic        rom_ack_q;
  logic [15:0] rom_dat_q;

  int n_checks = 0;
  int n_errors = 0;
  int acks;

  bootrom16_arb #(.TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
    .m0_sel_i(m0_sel_i), .m0_tga_i(m0_tga_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
    .m1_sel_i(m1_sel_i), .m1_tga_i(m1_tga_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_sel_o(s_sel_o), .s_tga_o(s_tga_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] rom_byte(input logic [31:0] a);
    case (a)
      32'h0:   rom_byte = 8'h12;
      32'h1:   rom_byte = 8'h34;
      default: rom_byte = a[7:0] + 8'h40;
    endcase
  endfunction

  // ROM: registered ack one cycle after cyc&stb, little-endian halfword.
  always @(posedge clk_i) begin
    if (rst_i) rom_ack_q <= 1'b0;
    else       rom_ack_q <= s_cyc_o & s_stb_o & rom_en;
    rom_dat_q <= {rom_byte(s_adr_o + 32'd1), rom_byte(s_adr_o)};
  end

  assign s_ack_i = rom_ack_q | stray_ack;
  assign s_dat_i = rom_dat_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic idle_masters();
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_sel_i = '0; m0_tga_i = 0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_sel_i = '0; m1_tga_i = 0;
  endtask

  task automatic do_reset();
    idle_masters();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic m0_read(input logic [31:0] a);
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = a; m0_sel_i = 2'b11;
  endtask

  task automatic m1_read(input logic [31:0] a);
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_adr_i = a; m1_sel_i = 2'b11;
  endtask

  initial begin
    idle_masters();
    rom_en    = 1'b1;
    stray_ack = 1'b0;
    rst_i     = 1'b1;
    tick();
    tick();
    #1;
    chk("rst_s_cyc", 32'(s_cyc_o), 32'd0);
    chk("rst_s_stb", 32'(s_stb_o), 32'd0);
    chk("rst_s_we",  32'(s_we_o),  32'd0);
    chk("rst_s_adr", s_adr_o,      32'd0);
    chk("rst_s_sel", 32'(s_sel_o), 32'd0);
    chk("rst_s_tga", 32'(s_tga_o), 32'd0);
    chk("rst_err0",  32'(m0_err_o), 32'd0);
    chk("rst_err1",  32'(m1_err_o), 32'd0);
    chk("rst_ack0",  32'(m0_ack_o), 32'd0);
    rst_i = 1'b0;

    // Single read by m0 at 0x0000
    tick();
    m0_read(32'h0); m0_tga_i = 1'b1;
    #1 chk("rd_c0_stb", 32'(s_stb_o), 32'd0);
    tick(); #1;
    chk("rd_c1_stb", 32'(s_stb_o), 32'd1);
    chk("rd_c1_cyc", 32'(s_cyc_o), 32'd1);
    chk("rd_c1_adr", s_adr_o, 32'h0);
    chk("rd_c1_sel", 32'(s_sel_o), 32'd3);
    chk("rd_c1_tga", 32'(s_tga_o), 32'd1);
    chk("rd_c1_ack0", 32'(m0_ack_o), 32'd0);
    tick(); #1;
    chk("rd_c2_ack0", 32'(m0_ack_o), 32'd1);
    chk("rd_c2_dat0", 32'(m0_dat_o), 32'h3412);
    chk("rd_c2_ack1", 32'(m1_ack_o), 32'd0);
    chk("rd_c2_stb",  32'(s_stb_o), 32'd0);
    tick();
    idle_masters();
    #1;
    chk("rd_c3_ack0", 32'(m0_ack_o), 32'd0);
    chk("rd_c3_cyc",  32'(s_cyc_o), 32'd0);

    // Contention: both masters request continuously
    do_reset();
    m0_read(32'h10);
    m1_read(32'h20);
    acks = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      chk($sformatf("ct_c%0d_ack0", c), 32'(m0_ack_o), 32'((c % 3 == 2) && ((c / 3) % 2 == 0)));
      chk($sformatf("ct_c%0d_ack1", c), 32'(m1_ack_o), 32'((c % 3 == 2) && ((c / 3) % 2 == 1)));
      if (c % 3 == 1) begin
        chk($sformatf("ct_c%0d_adr", c), s_adr_o, ((c / 3) % 2 == 1) ? 32'h20 : 32'h10);
      end
      if (m0_ack_o) begin
        acks++;
        chk("ct_dat0", 32'(m0_dat_o), 32'h5150);
      end
      if (m1_ack_o) begin
        acks++;
        chk("ct_dat1", 32'(m1_dat_o), 32'h6160);
      end
      tick();
    end
    idle_masters();
    chk("ct_ack_count", 32'(acks), 32'd4);

    // Write reject from m1
    do_reset();
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 32'h4; m1_sel_i = 2'b11;
    #1;
    chk("wr_c0_cyc", 32'(s_cyc_o), 32'd0);
    chk("wr_c0_err1", 32'(m1_err_o), 32'd0);
    tick(); #1;
    chk("wr_c1_err1", 32'(m1_err_o), 32'd1);
    chk("wr_c1_err0", 32'(m0_err_o), 32'd0);
    chk("wr_c1_cyc",  32'(s_cyc_o), 32'd0);
    chk("wr_c1_stb",  32'(s_stb_o), 32'd0);
    tick();
    idle_masters();
    #1;
    chk("wr_c2_err1", 32'(m1_err_o), 32'd0);
    chk("wr_c2_cyc",  32'(s_cyc_o), 32'd0);
    chk("wr_c2_stb",  32'(s_stb_o), 32'd0);

    // Timeout: ROM never acknowledges
    do_reset();
    rom_en = 1'b0;
    m0_read(32'h8);
    for (int c = 0; c < 12; c++) begin
      if (c == 11) idle_masters();
      #1;
      chk($sformatf("to_c%0d_err0", c), 32'(m0_err_o), 32'(c == 10));
      chk($sformatf("to_c%0d_ack0", c), 32'(m0_ack_o), 32'd0);
      chk($sformatf("to_c%0d_stb", c),  32'(s_stb_o), 32'(c == 1));
      chk($sformatf("to_c%0d_cyc", c),  32'(s_cyc_o), 32'((c >= 1) && (c <= 9)));
      tick();
    end
    rom_en = 1'b1;

    // Abort in REQ, then stray ack in IDLE, then a normal m1 read
    do_reset();
    m0_read(32'h0);
    tick();
    idle_masters();
    #1;
    chk("ab_c1_stb",  32'(s_stb_o), 32'd1);
    chk("ab_c1_ack0", 32'(m0_ack_o), 32'd0);
    tick(); #1;
    chk("ab_c2_cyc",  32'(s_cyc_o), 32'd0);
    chk("ab_c2_stb",  32'(s_stb_o), 32'd0);
    chk("ab_c2_ack0", 32'(m0_ack_o), 32'd0);
    chk("ab_c2_err0", 32'(m0_err_o), 32'd0);
    tick();
    stray_ack = 1'b1;
    #1;
    chk("ab_c3_ack0", 32'(m0_ack_o), 32'd0);
    chk("ab_c3_ack1", 32'(m1_ack_o), 32'd0);
    tick();
    stray_ack = 1'b0;
    m1_read(32'h20);
    tick(); #1;
    chk("ab_c5_stb", 32'(s_stb_o), 32'd1);
    chk("ab_c5_adr", s_adr_o, 32'h20);
    tick(); #1;
    chk("ab_c6_ack1", 32'(m1_ack_o), 32'd1);
    chk("ab_c6_dat1", 32'(m1_dat_o), 32'h6160);
    chk("ab_c6_ack0", 32'(m0_ack_o), 32'd0);
    tick();
    idle_masters();

    // Reset during WAIT, then a tie must go to m0
    do_reset();
    m0_read(32'h10); m0_sel_i = 2'b01; m0_tga_i = 1'b1;
    tick();
    tick(); #1;
    chk("rs_c2_ack0", 32'(m0_ack_o), 32'd1);
    rst_i = 1'b1;
    tick(); #1;
    chk("rs_c3_cyc",  32'(s_cyc_o), 32'd0);
    chk("rs_c3_stb",  32'(s_stb_o), 32'd0);
    chk("rs_c3_adr",  s_adr_o, 32'd0);
    chk("rs_c3_sel",  32'(s_sel_o), 32'd0);
    chk("rs_c3_tga",  32'(s_tga_o), 32'd0);
    chk("rs_c3_err0", 32'(m0_err_o), 32'd0);
    chk("rs_c3_err1", 32'(m1_err_o), 32'd0);
    chk("rs_c3_ack0", 32'(m0_ack_o), 32'd0);
    rst_i = 1'b0;
    m1_read(32'h20);
    tick(); #1;
    chk("rs_c4_stb", 32'(s_stb_o), 32'd1);
    chk("rs_c4_adr", s_adr_o, 32'h10);
    tick();
    tick();
    idle_masters();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
